instruction_loader: RTL and testbench

Boot-time writer for the per-core instruction memory. Accepts a byte stream (valid/ready) carrying a word count, big-endian 32-bit instruction words and an XOR checksum, and drives the instruction memory's synchronous write port one word at a time. It holds the attached core(s) in stall while loading, so the fetch side never reads a partially written program.

---
 rtl/instruction_loader.sv | 163 ++++++++++++++++
 tb/tb_instruction_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// instruction_loader
// Boot-time writer for a per-core instruction memory. Consumes a byte stream
// of the form: header N, 4*N big-endian data bytes, XOR checksum byte. Each
// assembled word is written through a synchronous memory write port. The
// attached core is held in stall for the whole session.
//
// Ports:
//   Clk          clock, all state changes on the rising edge
//   Rst_n        asynchronous active-low reset
//   Start        one-cycle pulse opening a session (only from IDLE/DONE/ERR)
//   RxData       stream byte
//   RxValid      stream byte valid
//   RxReady      loader accepts a byte this cycle
//   WrEn         one-cycle instruction memory write strobe
//   WrAddr       word address of the write
//   WrData       word being written
//   Busy         session in progress
//   CoreHold     stall for the fetch stage (same as Busy)
//   Done         sticky: last session completed with a good checksum
//   Error        sticky: last session failed
//   WordsLoaded  words written in the current or last session
module instruction_loader #(
  parameter int DEPTH_WORDS = 128,
  parameter int ADDR_W      = 7
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [31:0]       WrData,
  output logic              Busy,
  output logic              CoreHold,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   WordsLoaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_BYTE, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_rx_ready;
  logic              w_wr_en;
  logic              w_busy;
  logic              w_take;
  logic              w_start_ok;
  logic              w_hdr_bad;
  logic              w_last_word;
  logic [31:0]       w_hdr_ext;
  logic [ADDR_W:0]   w_loaded_inc;

  logic [ADDR_W:0]   r_n;
  logic [31:0]       r_word;
  logic [7:0]        r_csum;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_words_loaded;
  logic              r_done;
  logic              r_error;

  assign w_hdr_ext    = {24'd0, RxData};
  assign w_hdr_bad    = (RxData == 8'd0) || (w_hdr_ext > DEPTH_WORDS);
  assign w_loaded_inc = r_words_loaded + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last_word  = (w_loaded_inc == r_n);
  assign w_take       = RxValid && w_rx_ready;
  assign w_start_ok   = Start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERR));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_rx_ready   = 1'b0;
    w_wr_en      = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) w_state_next = S_HDR;
      end
      S_HDR: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
        if (RxValid) w_state_next = w_hdr_bad ? S_ERR : S_BYTE;
      end
      S_BYTE: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
        if (RxValid && (r_byte_cnt == 2'd3)) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_wr_en      = 1'b1;
        w_busy       = 1'b1;
        w_state_next = w_last_word ? S_CHK : S_BYTE;
      end
      S_CHK: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
        if (RxValid) w_state_next = (RxData == r_csum) ? S_DONE : S_ERR;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_n            <= '0;
      r_word         <= '0;
      r_csum         <= '0;
      r_byte_cnt     <= '0;
      r_words_loaded <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_csum         <= '0;
        r_byte_cnt     <= '0;
        r_words_loaded <= '0;
        r_done         <= 1'b0;
        r_error        <= 1'b0;
      end
      if (w_take) begin
        case (r_state)
          S_HDR: begin
            if (w_hdr_bad) r_error <= 1'b1;
            else           r_n     <= w_hdr_ext[ADDR_W:0];
          end
          S_BYTE: begin
            // first byte of a word ends up in [31:24] after four shifts
            r_word     <= {r_word[23:0], RxData};
            r_csum     <= r_csum ^ RxData;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          S_CHK: begin
            if (RxData == r_csum) r_done  <= 1'b1;
            else                  r_error <= 1'b1;
          end
          default: ;
        endcase
      end
      if (r_state == S_WRITE) r_words_loaded <= w_loaded_inc;
    end
  end

  // The write index equals the count of words already written.
  assign WrAddr      = r_words_loaded[ADDR_W-1:0];
  assign WrData      = r_word;
  assign WrEn        = w_wr_en;
  assign RxReady     = w_rx_ready;
  assign Busy        = w_busy;
  assign CoreHold    = w_busy;
  assign Done        = r_done;
  assign Error       = r_error;
  assign WordsLoaded = r_words_loaded;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed and randomized load
// sessions compared against a stream/word model built from the format rules.
module tb_instruction_loader;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  RxData = 8'd0;
  logic        RxValid = 1'b0;
  logic        RxReady;
  logic        WrEn;
  logic [6:0]  WrAddr;
  logic [31:0] WrData;
  logic        Busy;
  logic        CoreHold;
  logic        Done;
  logic        Error;
  logic [7:0]  WordsLoaded;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int b2b = 0;
  logic prev_wr = 1'b0;

  logic [7:0]  stream[$];
  logic [31:0] exp_words[$];
  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  instruction_loader #(.DEPTH_WORDS(128), .ADDR_W(7)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .RxData(RxData),
    .RxValid(RxValid), .RxReady(RxReady), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .Busy(Busy), .CoreHold(CoreHold), .Done(Done),
    .Error(Error), .WordsLoaded(WordsLoaded)
  );

  always #5 Clk = ~Clk;

  // write monitor, sampled mid-cycle
  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (WrEn) begin
      wq_addr.push_back(int'(WrAddr));
      wq_data.push_back(WrData);
      wq_cyc.push_back(cyc);
      if (prev_wr) b2b = b2b + 1;
    end
    prev_wr = WrEn;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: header, big-endian bytes of each word, XOR of data bytes (optionally corrupted).
  task automatic build_stream(input int n_hdr, input logic [7:0] ck_mask);
    logic [7:0] x;
    x = 8'd0;
    stream.delete();
    stream.push_back(8'(n_hdr));
    if (n_hdr >= 1 && n_hdr <= 128) begin
      for (int i = 0; i < n_hdr; i++) begin
        for (int b = 3; b >= 0; b--) begin
          logic [7:0] by;
          by = 8'(exp_words[i] >> (8 * b));
          stream.push_back(by);
          x = x ^ by;
        end
      end
      stream.push_back(x ^ ck_mask);
    end
  endtask

  task automatic send(input bit rnd, input int start_at, input int stop_after);
    int idx;
    int budget;
    bit acc;
    bit pulsed;
    idx = 0;
    budget = 5000;
    pulsed = 0;
    while (idx < stream.size() && idx != stop_after && budget > 0) begin
      RxData  = stream[idx];
      RxValid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      Start   = (idx == start_at) && !pulsed;
      if (Start) pulsed = 1;
      acc = RxValid && RxReady;
      @(posedge Clk); #1;
      Start = 1'b0;
      if (acc) idx++;
      budget--;
    end
    RxValid = 1'b0;
    if (budget == 0) chk("send_budget", 64'(idx), 64'(stream.size()));
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic run_session(input string nm, input int n_hdr, input logic [7:0] ck_mask,
                             input bit rnd, input int start_at);
    bit hdr_ok;
    bit good;
    int nw;
    hdr_ok = (n_hdr >= 1) && (n_hdr <= 128);
    good   = hdr_ok && (ck_mask == 8'd0);
    nw     = hdr_ok ? n_hdr : 0;
    build_stream(n_hdr, ck_mask);
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    pulse_start();
    chk({nm, "_hdr_ready"}, 64'(RxReady), 64'd1);
    chk({nm, "_hdr_busy"}, 64'(Busy), 64'd1);
    send(rnd, start_at, -1);
    chk({nm, "_done"}, 64'(Done), 64'(good));
    chk({nm, "_error"}, 64'(Error), 64'(!good));
    chk({nm, "_busy"}, 64'(Busy), 64'd0);
    chk({nm, "_hold"}, 64'(CoreHold), 64'd0);
    chk({nm, "_loaded"}, 64'(WordsLoaded), 64'(nw));
    chk({nm, "_nwrites"}, 64'(wq_addr.size()), 64'(nw));
    for (int i = 0; i < wq_addr.size() && i < nw; i++) begin
      chk({nm, "_addr"}, 64'(wq_addr[i]), 64'(i));
      chk({nm, "_data"}, 64'(wq_data[i]), 64'(exp_words[i]));
      if (!rnd && i > 0) chk({nm, "_cadence"}, 64'(wq_cyc[i] - wq_cyc[i-1]), 64'd5);
    end
    $display("session %s n=%0d writes=%0d done=%0b error=%0b", nm, n_hdr,
             wq_addr.size(), Done, Error);
  endtask

  initial begin
    int n;
    int base;
    // reset state
    #12;
    chk("rst_ready", 64'(RxReady), 64'd0);
    chk("rst_wren", 64'(WrEn), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_hold", 64'(CoreHold), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_error", 64'(Error), 64'd0);
    chk("rst_addr", 64'(WrAddr), 64'd0);
    chk("rst_data", 64'(WrData), 64'd0);
    chk("rst_loaded", 64'(WordsLoaded), 64'd0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    $display("reset released");

    // two-word program, valid held high
    exp_words = '{32'h20080005, 32'hAC080000};
    run_session("two_words", 2, 8'd0, 0, -1);

    // Start in DONE clears Done and opens HDR next cycle
    pulse_start();
    chk("restart_done", 64'(Done), 64'd0);
    chk("restart_ready", 64'(RxReady), 64'd1);
    $display("restart from DONE");

    // same program with random valid (Start during HDR above is harmless)
    run_session("two_words_rnd", 2, 8'd0, 1, -1);

    // illegal headers
    run_session("hdr_zero", 0, 8'd0, 0, -1);
    run_session("hdr_129", 129, 8'd0, 0, -1);

    // bad checksum: zero word with checksum 0x01
    exp_words = '{32'h00000000};
    run_session("bad_ck", 1, 8'h01, 0, -1);

    // full depth, word i = i
    exp_words.delete();
    for (int i = 0; i < 128; i++) exp_words.push_back(32'(i));
    run_session("full", 128, 8'd0, 0, -1);

    // Start pulsed while in BYTE has no effect
    exp_words = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
    run_session("start_mid", 3, 8'd0, 0, 3);

    // random sessions
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 16);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      run_session("random", n, ($urandom_range(0, 3) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'd0,
                  1, -1);
    end

    // reset after the 6th data byte
    exp_words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    build_stream(3, 8'd0);
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    pulse_start();
    send(0, -1, 7);
    base = wq_addr.size();
    chk("pre_rst_writes", 64'(base), 64'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(RxReady), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_hold", 64'(CoreHold), 64'd0);
    chk("mid_rst_wren", 64'(WrEn), 64'd0);
    chk("mid_rst_loaded", 64'(WordsLoaded), 64'd0);
    chk("mid_rst_addr", 64'(WrAddr), 64'd0);
    chk("mid_rst_data", 64'(WrData), 64'd0);
    chk("mid_rst_done", 64'(Done), 64'd0);
    chk("mid_rst_error", 64'(Error), 64'd0);
    RxValid = 1'b1;
    repeat (6) @(posedge Clk);
    #3 Rst_n = 1'b1;
    repeat (6) @(posedge Clk);
    #1;
    RxValid = 1'b0;
    chk("post_rst_writes", 64'(wq_addr.size()), 64'(base));
    chk("post_rst_idle", 64'(RxReady), 64'd0);
    $display("reset mid-session writes=%0d", wq_addr.size());

    chk("no_back_to_back", 64'(b2b), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
